// File: rtl/spmv_row_scheduler_if.sv
// Row-pointer and tag-beat streams of the SpMV row scheduler.
//   r_beg_*  : CSR row-pointer stream into the scheduler (valid/ready/data)
//   tag_*    : per-beat lane tags out to the product/row-reduction network
// Modports:
//   slave  : scheduler view (sinks r_beg, sources tags)
//   master : environment view (sources r_beg, sinks tags)
// Parameters must match those of the attached spmv_row_scheduler;
// ROW_WIDTH is the scheduler's derived row-index width.
interface spmv_row_scheduler_if #(
  parameter int PARALLELISM = 4,
  parameter int PTR_WIDTH   = 32,
  parameter int ROW_WIDTH   = 5
);
  logic                             r_beg_valid;
  logic                             r_beg_ready;
  logic [PTR_WIDTH-1:0]             r_beg_data;
  logic                             tag_valid;
  logic                             tag_ready;
  logic [PARALLELISM*ROW_WIDTH-1:0] tag_row;
  logic [PARALLELISM-1:0]           tag_lane_en;
  logic [PARALLELISM-1:0]           tag_last;
  logic [PARALLELISM-1:0]           tag_zero;

  modport slave (
    input  r_beg_valid, r_beg_data, tag_ready,
    output r_beg_ready, tag_valid, tag_row, tag_lane_en, tag_last, tag_zero
  );

  modport master (
    output r_beg_valid, r_beg_data, tag_ready,
    input  r_beg_ready, tag_valid, tag_row, tag_lane_en, tag_last, tag_zero
  );
endinterface

// File: rtl/spmv_row_scheduler.sv
// spmv_row_scheduler: walks the CSR row-pointer stream of one job and emits
// one tag beat per group of up to PARALLELISM nonzeros, never spanning rows.
// Empty rows produce a single lane-0 "zero" beat.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, num_rows  job start (sampled in IDLE), rows in job
//   busy, done       job in flight / one-cycle end-of-job pulse
//   err              sticky: row pointer went backwards
//   nnz_total        last pointer minus first, valid from done
//   bus              spmv_row_scheduler_if.slave (r_beg and tag streams)
// Optional: `define SPMV_ROW_SCHED_PERF_EN adds perf_beats / perf_stall
// (saturating, cleared on accepted start).
module spmv_row_scheduler #(
  parameter  int PARALLELISM = 4,
  parameter  int PTR_WIDTH   = 32,
  parameter  int MAX_ROWS    = 32,
  localparam int ROW_WIDTH   = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROW_WIDTH:0]   num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [PTR_WIDTH-1:0] nnz_total,
`ifdef SPMV_ROW_SCHED_PERF_EN
  output logic [31:0]          perf_beats,
  output logic [31:0]          perf_stall,
`endif
  spmv_row_scheduler_if.slave  bus
);
  localparam int CW = $clog2(PARALLELISM + 1);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH, EMIT, DONE} state_t;

  state_t                                 state;
  logic [ROW_WIDTH:0]                     nrows;
  logic [ROW_WIDTH-1:0]                   row;
  logic [PTR_WIDTH-1:0]                   base, ptr, endp;
  logic [CW-1:0]                          cur_n;
  logic                                   rb_ready_q, tv_q;
  logic [PARALLELISM-1:0][ROW_WIDTH-1:0]  trow_q;
  logic [PARALLELISM-1:0]                 ten_q, tlast_q, tzero_q;

  // Next beat, built from (start ptr, row end): in FETCH from the incoming
  // end pointer, in EMIT from the pointer advanced past the current beat.
  logic [PTR_WIDTH-1:0]                   nb_ptr, nb_end, nb_rem, ptr_adv;
  logic [CW-1:0]                          nb_n;
  logic                                   nb_closes, nb_empty;
  logic [PARALLELISM-1:0][ROW_WIDTH-1:0]  nb_row;
  logic [PARALLELISM-1:0]                 nb_en, nb_last, nb_zero;
  logic                                   rb_hs, tag_hs, row_closes;

  assign rb_hs      = rb_ready_q && bus.r_beg_valid;
  assign tag_hs     = tv_q && bus.tag_ready;
  // A lane-last bit is set exactly when the held beat finishes its row.
  assign row_closes = |tlast_q;
  assign ptr_adv    = ptr + PTR_WIDTH'(cur_n);

  always_comb begin
    nb_ptr    = (state == EMIT) ? ptr_adv : ptr;
    nb_end    = (state == EMIT) ? endp : bus.r_beg_data;
    nb_rem    = nb_end - nb_ptr;
    nb_closes = (nb_rem <= PTR_WIDTH'(PARALLELISM));
    nb_n      = nb_closes ? nb_rem[CW-1:0] : CW'(PARALLELISM);
    nb_empty  = (nb_n == '0);
  end

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    assign nb_en[i]   = nb_empty ? (i == 0) : (CW'(i) < nb_n);
    assign nb_zero[i] = nb_empty && (i == 0);
    assign nb_last[i] = nb_empty ? (i == 0) : (nb_closes && (nb_n == CW'(i + 1)));
    assign nb_row[i]  = nb_en[i] ? row : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      nnz_total  <= '0;
      nrows      <= '0;
      row        <= '0;
      base       <= '0;
      ptr        <= '0;
      endp       <= '0;
      cur_n      <= '0;
      rb_ready_q <= 1'b0;
      tv_q       <= 1'b0;
      trow_q     <= '0;
      ten_q      <= '0;
      tlast_q    <= '0;
      tzero_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err   <= 1'b0;
          busy  <= 1'b1;
          nrows <= num_rows;
          row   <= '0;
          if (num_rows == '0) begin
            nnz_total <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            rb_ready_q <= 1'b1;
            state      <= FETCH0;
          end
        end
        FETCH0: if (rb_hs) begin
          base  <= bus.r_beg_data;
          ptr   <= bus.r_beg_data;
          state <= FETCH;
        end
        FETCH: if (rb_hs) begin
          endp       <= bus.r_beg_data;
          rb_ready_q <= 1'b0;
          if (bus.r_beg_data < ptr) begin
            err       <= 1'b1;
            nnz_total <= bus.r_beg_data - base;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            tv_q    <= 1'b1;
            trow_q  <= nb_row;
            ten_q   <= nb_en;
            tlast_q <= nb_last;
            tzero_q <= nb_zero;
            cur_n   <= nb_n;
            state   <= EMIT;
          end
        end
        EMIT: if (tag_hs) begin
          ptr <= ptr_adv;
          if (!row_closes) begin
            trow_q  <= nb_row;
            ten_q   <= nb_en;
            tlast_q <= nb_last;
            tzero_q <= nb_zero;
            cur_n   <= nb_n;
          end else begin
            tv_q    <= 1'b0;
            trow_q  <= '0;
            ten_q   <= '0;
            tlast_q <= '0;
            tzero_q <= '0;
            if ({1'b0, row} == nrows - (ROW_WIDTH+1)'(1)) begin
              nnz_total <= endp - base;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              row        <= row + ROW_WIDTH'(1);
              rb_ready_q <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_beg_ready = rb_ready_q;
  assign bus.tag_valid   = tv_q;
  assign bus.tag_row     = trow_q;
  assign bus.tag_lane_en = ten_q;
  assign bus.tag_last    = tlast_q;
  assign bus.tag_zero    = tzero_q;

`ifdef SPMV_ROW_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else if (state == IDLE && start) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (tag_hs && perf_beats != '1)
        perf_beats <= perf_beats + 32'd1;
      if (tv_q && !bus.tag_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
